// File: rtl/ula_muldiv_iter_if.sv
// ula_muldiv_iter_if
//   Request/response bundle between the EX-stage issue logic and the
//   iterative RV32M multiply/divide unit.
//   master : issue side   (drives start/funct7/funct3/op_a/op_b)
//   slave  : muldiv unit  (drives busy/done/result/err)
interface ula_muldiv_iter_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [6:0]      funct7;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic            err;

  modport master (
    output start, funct7, funct3, op_a, op_b,
    input  busy, done, result, err
  );

  modport slave (
    input  start, funct7, funct3, op_a, op_b,
    output busy, done, result, err
  );
endinterface

// File: rtl/ula_muldiv_iter.sv
// ula_muldiv_iter
//   Iterative RV32M multiply/divide unit (MUL, MULH, MULHSU, MULHU, DIV, DIVU,
//   REM, REMU). Multiply is a right-shifting shift/add over magnitudes, divide
//   is restoring division over magnitudes; signs are applied at the end.
//   Divide-by-zero, signed overflow and non-M funct7 finish the cycle after
//   accept. busy stays high from the cycle after accept through DONE.
// Ports
//   clk      rising-edge clock
//   rst      synchronous reset, active-high (aborts any operation)
//   bus      ula_muldiv_iter_if.slave: start/funct7/funct3/op_a/op_b in,
//            busy/done/result/err out (all outputs registered)
// Configuration macro
//   MULDIV_FAST_MUL_EN : multiplies use a single-cycle product, done at T+1.
module ula_muldiv_iter #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input logic               clk,
  input logic               rst,
  ula_muldiv_iter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  localparam logic [6:0]       M_FUNCT7 = 7'b0000001;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  MIN_VAL  = {1'b1, {(XLEN-1){1'b0}}};

  state_t              state, state_nxt;
  logic [2*XLEN-1:0]   acc, acc_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [2:0]          f3, f3_nxt;
  logic [XLEN-1:0]     ma, ma_nxt;
  logic [XLEN-1:0]     mb, mb_nxt;
  logic                neg_q, neg_q_nxt;
  logic                neg_r, neg_r_nxt;
  logic [XLEN-1:0]     result, result_nxt;
  logic                done, done_nxt;
  logic                err, err_nxt;
  logic                busy;

  // Decode of the incoming request (valid only while IDLE samples start)
  logic            in_div, in_rem, in_signed_a, in_signed_b, in_sa, in_sb;
  logic [XLEN-1:0] in_ma, in_mb;
  assign in_div      = bus.funct3[2];
  assign in_rem      = bus.funct3[2] & bus.funct3[1];
  // a is signed for MUL/MULH/MULHSU/DIV/REM; b for MUL/MULH/DIV/REM
  assign in_signed_a = bus.funct3[2] ? ~bus.funct3[0] : (bus.funct3[1:0] != 2'b11);
  assign in_signed_b = bus.funct3[2] ? ~bus.funct3[0] : ~bus.funct3[1];
  assign in_sa       = in_signed_a & bus.op_a[XLEN-1];
  assign in_sb       = in_signed_b & bus.op_b[XLEN-1];
  assign in_ma       = in_sa ? -bus.op_a : bus.op_a;
  assign in_mb       = in_sb ? -bus.op_b : bus.op_b;

`ifdef MULDIV_FAST_MUL_EN
  // Sign-extending to 2*XLEN makes the low 2*XLEN product bits exact
  logic [2*XLEN-1:0] fast_a, fast_b, fast_prod;
  assign fast_a    = {{XLEN{in_sa}}, bus.op_a};
  assign fast_b    = {{XLEN{in_sb}}, bus.op_b};
  assign fast_prod = fast_a * fast_b;
`endif

  // One multiply step: add multiplicand into the high half when the current
  // multiplier bit (acc[0]) is set, then shift the whole accumulator right.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_acc;
  assign mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? ma : {XLEN{1'b0}})};
  assign mul_acc = {mul_sum, acc[XLEN-1:1]};

  // One restoring-divide step on {remainder, dividend/quotient}: shift left,
  // trial-subtract the divisor, keep the difference when it is non-negative.
  logic [XLEN:0]     div_trial;
  logic [2*XLEN-1:0] div_acc;
  assign div_trial = acc[2*XLEN-1:XLEN-1] - {1'b0, mb};
  assign div_acc   = div_trial[XLEN] ? {acc[2*XLEN-2:0], 1'b0}
                                     : {div_trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};

  // Final value after the last step, with signs restored
  logic [2*XLEN-1:0] step, prod_fin;
  logic [XLEN-1:0]   fin_result;
  assign step       = f3[2] ? div_acc : mul_acc;
  assign prod_fin   = neg_q ? -step : step;
  assign fin_result = f3[2] ? (f3[1] ? (neg_r ? -step[2*XLEN-1:XLEN] : step[2*XLEN-1:XLEN])
                                     : (neg_q ? -step[XLEN-1:0] : step[XLEN-1:0]))
                            : ((f3 == 3'b000) ? prod_fin[XLEN-1:0] : prod_fin[2*XLEN-1:XLEN]);

  // Next-state and next-output logic
  always_comb begin
    state_nxt  = state;
    acc_nxt    = acc;
    cnt_nxt    = cnt;
    f3_nxt     = f3;
    ma_nxt     = ma;
    mb_nxt     = mb;
    neg_q_nxt  = neg_q;
    neg_r_nxt  = neg_r;
    result_nxt = result;
    done_nxt   = 1'b0;
    err_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          f3_nxt    = bus.funct3;
          ma_nxt    = in_ma;
          mb_nxt    = in_mb;
          neg_q_nxt = in_sa ^ in_sb;
          neg_r_nxt = in_sa;
          cnt_nxt   = {CNT_W{1'b0}};
          if (bus.funct7 != M_FUNCT7) begin
            state_nxt  = DONE;
            result_nxt = {XLEN{1'b0}};
            err_nxt    = 1'b1;
            done_nxt   = 1'b1;
          end else if (in_div && (bus.op_b == {XLEN{1'b0}})) begin
            state_nxt  = DONE;
            result_nxt = in_rem ? bus.op_a : {XLEN{1'b1}};
            done_nxt   = 1'b1;
          end else if (in_div && !bus.funct3[0] && (bus.op_a == MIN_VAL) &&
                       (bus.op_b == {XLEN{1'b1}})) begin
            state_nxt  = DONE;
            result_nxt = in_rem ? {XLEN{1'b0}} : bus.op_a;
            done_nxt   = 1'b1;
`ifdef MULDIV_FAST_MUL_EN
          end else if (!in_div) begin
            state_nxt  = DONE;
            result_nxt = (bus.funct3 == 3'b000) ? fast_prod[XLEN-1:0]
                                                : fast_prod[2*XLEN-1:XLEN];
            done_nxt   = 1'b1;
`endif
          end else begin
            state_nxt = BUSY;
            // Divide iterates on the dividend, multiply on the multiplier
            acc_nxt   = {{XLEN{1'b0}}, (in_div ? in_ma : in_mb)};
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      BUSY: begin
        acc_nxt = step;
        cnt_nxt = cnt + CNT_W'(1);
        if (cnt == LAST_CNT) begin
          state_nxt  = DONE;
          result_nxt = fin_result;
          done_nxt   = 1'b1;
        end else begin
          state_nxt = BUSY;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      acc    <= {(2*XLEN){1'b0}};
      cnt    <= {CNT_W{1'b0}};
      f3     <= 3'b000;
      ma     <= {XLEN{1'b0}};
      mb     <= {XLEN{1'b0}};
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      result <= {XLEN{1'b0}};
      done   <= 1'b0;
      err    <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state  <= state_nxt;
      acc    <= acc_nxt;
      cnt    <= cnt_nxt;
      f3     <= f3_nxt;
      ma     <= ma_nxt;
      mb     <= mb_nxt;
      neg_q  <= neg_q_nxt;
      neg_r  <= neg_r_nxt;
      result <= result_nxt;
      done   <= done_nxt;
      err    <= err_nxt;
      busy   <= (state_nxt != IDLE);
    end
  end

  assign bus.busy   = busy;
  assign bus.done   = done;
  assign bus.result = result;
  assign bus.err    = err;

endmodule
